// File: rtl/seg7_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// seg7_pkg
// Shared constants and types for the 4-digit 7-segment scan controller.
// Revision: 1.0
// ============================================================================
package seg7_pkg;

    localparam int         NDIG    = 4;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-high segment patterns {g,f,e,d,c,b,a}, entry n = hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } image_t;

    localparam image_t IMAGE_DARK = '{data: 16'h0000, dp: 4'h0, blank: 4'hF};

    function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
        return ~{dp, HEX_SEG[nib]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// seg7_decode
// Combinational hex nibble + decimal point to active-low segment vector.
// Revision: 1.0
// ============================================================================
module seg7_decode (
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg_n
);
    import seg7_pkg::*;

    assign o_seg_n = seg_encode(i_nib, i_dp);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// seg7_scan_ctrl
// Multiplexed scan of a 4-digit common-anode display with a double-buffered
// image write port; the pending image is swapped in only at frame boundaries.
// Revision: 1.0
// ============================================================================
module seg7_scan_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DIGIT_HZ  = 1000,
    parameter int BLANK_CYC = 500
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_VAL,
    input  logic [15:0] WR_DATA,
    input  logic [3:0]  WR_DP,
    input  logic [3:0]  WR_BLANK,
    output logic        WR_RDY,
    output logic        FRAME,
    output logic [7:0]  nSEG,
    output logic [3:0]  nAN
);
    import seg7_pkg::*;

    localparam int SLOT_CYC = CLK_HZ / DIGIT_HZ;
    localparam int c_cnt_w  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int c_idx_w  = $clog2(NDIG);

    localparam logic [c_cnt_w-1:0] c_slot_last = c_cnt_w'(SLOT_CYC - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(NDIG - 1);

    generate
        if ((SLOT_CYC < BLANK_CYC + 1) || (DIGIT_HZ > CLK_HZ)) begin : g_bad_params
            $error("seg7_scan_ctrl: slot shorter than blanking or DIGIT_HZ above CLK_HZ");
        end
    endgenerate

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_idx;
    image_t             r_act;
    image_t             r_pnd;
    logic               r_pend;
    logic [3:0]         r_nan;
    logic [7:0]         r_nseg;
    logic               r_frame;

    logic               w_slot_end;
    logic               w_frame_end;
    logic               w_blank_ph;
    logic               w_dark;
    logic [3:0]         w_nib;
    logic               w_dp;
    logic [7:0]         w_seg_n;

    assign w_slot_end  = (r_cnt == c_slot_last);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);
    assign w_blank_ph  = (int'(r_cnt) < BLANK_CYC);
    assign w_dark      = w_blank_ph || r_act.blank[r_idx];
    assign w_nib       = r_act.data[{r_idx, 2'b00} +: 4];
    assign w_dp        = r_act.dp[r_idx];

    seg7_decode u_decode (
        .i_nib   (w_nib),
        .i_dp    (w_dp),
        .o_seg_n (w_seg_n)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A write landing on the boundary edge itself sees r_pend = 0, so it is
    // only captured here and swapped at the end of the following frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_act  <= IMAGE_DARK;
            r_pnd  <= IMAGE_DARK;
            r_pend <= 1'b0;
        end else if (w_frame_end && r_pend) begin
            r_act  <= r_pnd;
            r_pend <= 1'b0;
        end else if (WR_VAL && !r_pend) begin
            r_pnd  <= '{data: WR_DATA, dp: WR_DP, blank: WR_BLANK};
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_nan   <= AN_OFF;
            r_nseg  <= SEG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_frame <= (r_cnt == '0) && (r_idx == '0);
            if (w_dark) begin
                r_nan  <= AN_OFF;
                r_nseg <= SEG_OFF;
            end else begin
                r_nan  <= ~(NDIG'(1) << r_idx);
                r_nseg <= w_seg_n;
            end
        end
    end

    assign WR_RDY = ~r_pend;
    assign FRAME  = r_frame;
    assign nSEG   = r_nseg;
    assign nAN    = r_nan;

endmodule
`default_nettype wire
